// File: rtl/lsu_axi_master.sv
// lsu_axi_master
//   AXI-lite data-side master for the load/store unit. It takes one LSU
//   request at a time and runs it on the bus. Loads use AR/R and stores use
//   AW/W/B. Stores get byte-lane strobes and replicated write data. Loads
//   get lane extraction plus sign or zero extension.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_*             LSU request: valid/ready handshake, we, byte address,
//                     right-aligned store data, size (0 b, 1 h, 2 w),
//                     unsigned-load flag
//   resp_*            one-cycle completion pulse, extended load data, error
//   ar*/r*            AXI-lite read address / read data channels
//   aw*/w*/b*         AXI-lite write address / write data / write response
//
// All bus outputs and resp_* are flops. req_ready is a decode of the state
// register.
module lsu_axi_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic        awvalid_q, awvalid_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        illegal;
  logic [3:0]  strb_req;
  logic [31:0] wdata_req;
  logic [31:0] lane;
  logic [31:0] ld_ext;

  // Request decode: alignment check, strobes and lane replication.
  always_comb begin
    illegal = (req_size == 2'd3)
            | ((req_size == 2'd1) & req_addr[0])
            | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));
    case (req_size)
      2'd0: begin
        strb_req  = 4'b0001 << req_addr[1:0];
        wdata_req = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        strb_req  = 4'b0011 << req_addr[1:0];
        wdata_req = {2{req_wdata[15:0]}};
      end
      default: begin
        strb_req  = 4'b1111;
        wdata_req = req_wdata;
      end
    endcase
  end

  // Load data: shift the addressed lane down, then extend by size.
  always_comb begin
    lane = rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    ld_ext = uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'd1:    ld_ext = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awaddr_d     = awaddr_q;
    awvalid_d    = awvalid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d  = req_addr[1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          if (illegal) begin
            // The error pulse is raised on the accept edge so it appears
            // one cycle after acceptance; ERR then holds off new requests.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = ERR;
          end else if (req_we) begin
            awaddr_d  = req_addr;
            wdata_d   = wdata_req;
            wstrb_d   = strb_req;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = req_addr;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (rvalid) begin
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = (rresp != 2'b00);
          resp_rdata_d = (rresp != 2'b00) ? '0 : ld_ext;
          state_d      = IDLE;
        end
      end

      WR_REQ: begin
        // AW and W retire independently; the flags remember which one has.
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (bvalid) begin
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = (bresp != 2'b00);
          state_d      = IDLE;
        end
      end

      ERR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awaddr_q     <= awaddr_d;
      awvalid_q    <= awvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign awaddr     = awaddr_q;
  assign awvalid    = awvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb_lsu_axi_master
//   Directed bench for lsu_axi_master. A delay-programmable AXI-lite slave
//   model runs on the falling clock edge; a monitor counts bus activity one
//   step after each rising edge. Expected values are hand-computed constants.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic        wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  lsu_axi_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave model controls and observations
  int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
  logic [31:0] r_data_v;
  logic [1:0]  r_resp_v, b_resp_v;
  int          ar_c, r_c, aw_c, w_c, b_c;
  bit          ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend, aw_dn, w_dn;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rdata = '0; rresp = '0; bresp = '0;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        r_pend = 0; b_pend = 0; aw_dn = 0; w_dn = 0;
      end else begin
        // Handshakes flagged last falling edge completed on the rising edge.
        if (ar_hs) begin arready = 0; ar_c = 0; r_pend = 1; r_c = 0; end
        if (r_hs)  rvalid = 0;
        if (aw_hs) begin awready = 0; aw_c = 0; aw_dn = 1; end
        if (w_hs)  begin wready = 0; w_c = 0; w_dn = 1; end
        if (b_hs)  bvalid = 0;
        if (aw_dn && w_dn) begin aw_dn = 0; w_dn = 0; b_pend = 1; b_c = 0; end
        if (arvalid && !arready) begin if (ar_c >= ar_dly) arready = 1; else ar_c++; end
        if (r_pend) begin
          if (r_c >= r_dly) begin rvalid = 1; rdata = r_data_v; rresp = r_resp_v; r_pend = 0; end
          else r_c++;
        end
        if (awvalid && !awready) begin if (aw_c >= aw_dly) awready = 1; else aw_c++; end
        if (wvalid && !wready) begin if (w_c >= w_dly) wready = 1; else w_c++; end
        if (b_pend) begin
          if (b_c >= b_dly) begin bvalid = 1; bresp = b_resp_v; b_pend = 0; end
          else b_c++;
        end
        ar_hs = arvalid && arready;
        if (ar_hs) cap_araddr = araddr;
        r_hs  = rvalid && rready;
        aw_hs = awvalid && awready;
        if (aw_hs) cap_awaddr = awaddr;
        w_hs  = wvalid && wready;
        if (w_hs) begin cap_wdata = wdata; cap_wstrb = wstrb; end
        b_hs  = bvalid && bready;
      end
    end
  end

  // Monitor, sampled just after each rising edge
  int          n_resp = 0, n_busv = 0, n_aw_only = 0, n_bready = 0, ar_chg = 0;
  bit          ar_seen = 0;
  logic [31:0] ar_first;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (resp_valid) n_resp++;
      if (arvalid || awvalid) n_busv++;
      if (awvalid && !wvalid) n_aw_only++;
      if (bready) n_bready++;
      if (arvalid) begin
        if (ar_seen && araddr !== ar_first) ar_chg++;
        if (!ar_seen) begin ar_seen = 1; ar_first = araddr; end
      end else ar_seen = 0;
    end
  end

  int          last_acc, last_resp;
  logic [31:0] last_d;
  logic        last_e;

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic u);
    int n = 0;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    req_size = sz; req_unsigned = u;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check("req_accept_timeout", {31'b0, req_ready}, 32'd1);
    last_acc = cyc;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!resp_valid && n < 200) begin @(negedge clk); n++; end
    check("resp_timeout", {31'b0, resp_valid}, 32'd1);
    last_resp = cyc; last_d = resp_rdata; last_e = resp_err;
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] sz,
                    input logic u, input logic [31:0] bus, input logic [1:0] rr,
                    input logic [31:0] exp_d, input logic exp_e);
    r_data_v = bus; r_resp_v = rr;
    issue(1'b0, a, 32'h0, sz, u);
    wait_resp();
    check({tag, "_rdata"}, last_d, exp_d);
    check({tag, "_err"}, {31'b0, last_e}, {31'b0, exp_e});
    check({tag, "_araddr"}, cap_araddr, a);
  endtask

  task automatic st(input string tag, input logic [31:0] a, input logic [1:0] sz,
                    input logic [31:0] d, input logic [1:0] br,
                    input logic [3:0] exp_strb, input logic [31:0] exp_wd, input logic exp_e);
    b_resp_v = br;
    issue(1'b1, a, d, sz, 1'b0);
    wait_resp();
    check({tag, "_err"}, {31'b0, last_e}, {31'b0, exp_e});
    check({tag, "_rdata"}, last_d, 32'h0);
    check({tag, "_awaddr"}, cap_awaddr, a);
    check({tag, "_wstrb"}, {28'b0, cap_wstrb}, {28'b0, exp_strb});
    check({tag, "_wdata"}, cap_wdata, exp_wd);
  endtask

  task automatic set_dly(input int a, input int r, input int aw, input int w, input int b);
    ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int b0, b1, b2;
  int t_resp;

  initial begin
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 0;
    r_data_v = '0; r_resp_v = '0; b_resp_v = '0;
    set_dly(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ctl", {25'b0, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err}, 32'h0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_wstrb", {28'b0, wstrb}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    #2 rst_n = 1;
    @(negedge clk);

    // Word load with slow R; one pulse, araddr stable
    set_dly(0, 5, 0, 0, 0);
    b0 = n_resp; b1 = ar_chg;
    ld("ld_word", 32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0);
    repeat (3) @(negedge clk);
    check("ld_word_pulses", n_resp - b0, 32'd1);
    check("ld_word_araddr_stable", ar_chg - b1, 32'd0);

    // Minimum-latency load
    set_dly(0, 0, 0, 0, 0);
    ld("ld_min", 32'h8000_0008, 2'd2, 1'b0, 32'h0123_4567, 2'b00, 32'h0123_4567, 1'b0);
    check("ld_min_latency", last_resp - last_acc, 32'd3);

    // Byte and half extraction / extension
    ld("ld_b_s", 32'h8000_0003, 2'd0, 1'b0, 32'h80FF_0000, 2'b00, 32'hFFFF_FF80, 1'b0);
    ld("ld_b_u", 32'h8000_0003, 2'd0, 1'b1, 32'h80FF_0000, 2'b00, 32'h0000_0080, 1'b0);
    ld("ld_b1_u", 32'h8000_0001, 2'd0, 1'b1, 32'h1122_3344, 2'b00, 32'h0000_0033, 1'b0);
    ld("ld_h2_s", 32'h8000_0002, 2'd1, 1'b0, 32'hBEEF_1234, 2'b00, 32'hFFFF_BEEF, 1'b0);
    ld("ld_h0_s", 32'h8000_0000, 2'd1, 1'b0, 32'hBEEF_9234, 2'b00, 32'hFFFF_9234, 1'b0);
    ld("ld_h0_u", 32'h8000_0000, 2'd1, 1'b1, 32'hBEEF_9234, 2'b00, 32'h0000_9234, 1'b0);

    // Half store; W granted 3 cycles before AW
    set_dly(0, 0, 3, 0, 0);
    b0 = n_aw_only; b1 = n_bready;
    st("st_half", 32'h8000_0002, 2'd1, 32'h0000_1234, 2'b00, 4'b1100, 32'h1234_1234, 1'b0);
    check("st_half_aw_held", n_aw_only - b0, 32'd3);
    check("st_half_b_wait", n_bready - b1, 32'd1);
    check("st_half_latency", last_resp - last_acc, 32'd6);

    // Minimum-latency byte store
    set_dly(0, 0, 0, 0, 0);
    st("st_byte", 32'h8000_0001, 2'd0, 32'h0000_00AB, 2'b00, 4'b0010, 32'hABAB_ABAB, 1'b0);
    check("st_min_latency", last_resp - last_acc, 32'd3);

    // Illegal requests: no bus activity, error at T+1
    b2 = n_busv;
    issue(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0);
    wait_resp();
    check("misal_w_err", {31'b0, last_e}, 32'd1);
    check("misal_w_rdata", last_d, 32'h0);
    check("misal_w_latency", last_resp - last_acc, 32'd1);
    issue(1'b1, 32'h8000_0003, 32'h5555_5555, 2'd1, 1'b0);
    wait_resp();
    check("misal_h_err", {31'b0, last_e}, 32'd1);
    issue(1'b0, 32'h8000_0000, 32'h0, 2'd3, 1'b0);
    wait_resp();
    check("size3_err", {31'b0, last_e}, 32'd1);
    repeat (2) @(negedge clk);
    check("illegal_no_bus", n_busv - b2, 32'd0);

    // Bus error on a store, then back-to-back acceptance
    st("st_berr", 32'h8000_0010, 2'd2, 32'hCAFE_F00D, 2'b10, 4'b1111, 32'hCAFE_F00D, 1'b1);
    t_resp = last_resp;
    check("b2b_req_ready", {31'b0, req_ready}, 32'd1);
    ld("ld_b2b", 32'h8000_0014, 2'd2, 1'b0, 32'h5A5A_0001, 2'b00, 32'h5A5A_0001, 1'b0);
    check("b2b_accept_cycle", last_acc, t_resp);
    ld("ld_rerr", 32'h8000_0018, 2'd2, 1'b0, 32'hFFFF_FFFF, 2'b11, 32'h0, 1'b1);

    // Random stalls on every channel
    for (int i = 0; i < 6; i++) begin
      set_dly($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7));
      ld("rnd_ld", 32'h8000_0006, 2'd1, 1'b1, 32'hA5C3_0000, 2'b00, 32'h0000_A5C3, 1'b0);
      st("rnd_st", 32'h8000_0001, 2'd0, 32'h0000_0077, 2'b00, 4'b0010, 32'h7777_7777, 1'b0);
    end

    // Reset while waiting in RD_DATA
    set_dly(0, 30, 0, 0, 0);
    b0 = n_resp;
    r_data_v = 32'h1111_2222; r_resp_v = 2'b00;
    issue(1'b0, 32'h8000_0020, 32'h0, 2'd2, 1'b0);
    for (int n = 0; n < 20 && !rready; n++) @(negedge clk);
    check("rstmid_in_rd_data", {31'b0, rready}, 32'd1);
    #2 rst_n = 0;
    @(negedge clk);
    check("rstmid_ctl", {26'b0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'h0);
    #2 rst_n = 1;
    @(negedge clk);
    check("rstmid_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (40) @(negedge clk);
    check("rstmid_no_resp", n_resp - b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
